imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface; the program counter is the initiator.
- Accepts word-fetch addresses over a valid/ready request channel.
- Returns the instruction word after a fixed pipeline latency over a valid/ready response channel, with a credit-limited response buffer so backpressure never drops data.
- Flags misaligned and out-of-range fetches and includes a synchronous program-load port for initialising the instruction store.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of instruction word 0.
- DEPTH, 1024, number of 32-bit instruction words stored.
- LATENCY, 2, cycles from request accept to response eligible; legal range 1-4.
- QDEPTH, 4, maximum outstanding requests (in pipeline plus buffered); power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address of the instruction to fetch.
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  consumer accepts the response this cycle.
- rsp_data  output  32  instruction word; 32'h0 when rsp_err=1.
- rsp_err  output  1  fetch was misaligned or out of range.
- rsp_addr  output  32  echo of the request address belonging to this response.
- prog_we  input  1  program-load write enable.
- prog_idx  input  log2(DEPTH)  word index for the program-load write.
- prog_data  input  32  word to store.

Behaviour:
- Reset values (async, immediate on rst high): req_ready=0 while rst high, then 1 the first cycle after release; rsp_valid=0, rsp_data=0, rsp_err=0, rsp_addr=0.
- Reset clears pipeline valid bits, buffer pointers and the outstanding counter. Memory contents are not reset.
- Reset mid-operation discards all in-flight and buffered requests; no response is ever produced for them.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. req_ready = (outstanding < QDEPTH) and is combinational on the counter only, never on req_valid.
- Outstanding counter: +1 on accept, -1 on response handshake (rsp_valid && rsp_ready), unchanged when both occur in the same cycle. It never exceeds QDEPTH or goes below 0.
- Decode at accept:
  - Word index = (req_addr - BASE_ADDR) >> 2, using 32-bit unsigned subtraction.
  - err = (req_addr[1:0] != 0) OR (req_addr < BASE_ADDR) OR (req_addr >= BASE_ADDR + 4*DEPTH).
  - Wrap-around of the subtraction must not alias into range: the range compare governs.
- Pipeline: a LATENCY-stage shift register carries {valid, addr, err, data}. The memory read occurs in stage 1.
- Latency: the entry enters the response buffer at the end of cycle LATENCY after accept.
- Response buffer:
  - FIFO of QDEPTH entries; rsp_* outputs show the head entry.
  - With an empty buffer and rsp_ready=1, a request accepted at edge N gives rsp_valid high from edge N+LATENCY.
  - The credit scheme guarantees the buffer never overflows, so the pipeline never stalls.
- Ordering: responses are returned strictly in request order.
- Throughput: one request per cycle sustained when QDEPTH >= LATENCY+1 and rsp_ready is held high.
- Output stability: rsp_valid, rsp_data, rsp_err and rsp_addr are held stable while rsp_valid=1 and rsp_ready=0.
- Program load: when prog_we=1, mem[prog_idx] is written at the edge.
  - A same-cycle fetch read of the same index returns the OLD word (read-before-write).
  - A fetch of that index issued on a later cycle returns the new word.
- Error responses occupy a normal slot with identical latency and ordering, and rsp_data=32'h0.
- No combinational path from req_valid to rsp_*. No combinational path from rsp_ready to req_ready; the counter is the only coupling.

Test Plan:
- Reset then basic fetch: load mem[0]=32'h2008_0005 and mem[1]=32'h2009_0003; request 32'h3000 with rsp_ready=1. Expect rsp_valid exactly 2 cycles later with rsp_data=32'h2008_0005, rsp_err=0, rsp_addr=32'h3000.
- Streaming: back-to-back requests 32'h3000, 3004, 3008, 300C with rsp_ready=1. Expect req_ready held 1 and four consecutive responses in order, one per cycle.
- Backpressure: rsp_ready=0 while issuing requests. Expect req_ready to fall after exactly 4 accepts and rsp_* stable. Raise rsp_ready: expect 4 responses in order and req_ready=1 again the cycle after the first handshake.
- Errors:
  - 32'h3002 gives rsp_err=1, data 0.
  - 32'h2FFC gives err=1.
  - 32'h3000+4*1024 gives err=1.
  - 32'h3FFC gives err=0.
  - Each error response arrives in sequence with normal latency.
- Program-load collision: prog_we=1 with prog_idx=5 and prog_data=32'hDEAD_BEEF, in the same cycle as a fetch of 32'h3014 (old word 32'h1111_1111). Expect 32'h1111_1111. A follow-up fetch returns 32'hDEAD_BEEF.
- Reset mid-operation: issue 3 requests, assert rst one cycle later. Expect rsp_valid=0 immediately, no stale responses after release, and req_ready=1 with a full credit of 4 accepts available.

Source files
------------

// File: rtl/imem_fetch_responder_if.sv
// rtl/imem_fetch_responder_if.sv - fetch request/response channel bundle
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] rsp_addr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - fixed-latency instruction store responder
// Credit-limited: outstanding work never exceeds the response buffer, so the pipeline never stalls.
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter int          QDEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_fetch_responder_if.slave    bus,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_idx,
    input  logic [31:0]              prog_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    // 33-bit bound so BASE_ADDR + 4*DEPTH cannot wrap
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] outstanding;
    logic          accept;
    logic          pop;
    logic          push;
    logic          dec_err;
    logic [AW-1:0] dec_idx;

    logic [LATENCY-1:0] pv;
    logic [31:0]        pa [LATENCY];
    logic               pe [LATENCY];
    logic [31:0]        pd [LATENCY];

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [31:0]  fa [QDEPTH];
    logic [31:0]  fd [QDEPTH];
    logic         fe [QDEPTH];

    always_comb begin
        dec_idx = AW'((bus.req_addr - BASE_ADDR) >> 2);
        dec_err = (bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr < BASE_ADDR)
               || ({1'b0, bus.req_addr} >= END_ADDR);
    end

    assign bus.req_ready = !rst && (outstanding < CW'(QDEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign push          = pv[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Stage 1 reads the store with non-blocking semantics, so a same-edge program write is not seen.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_idx] <= prog_data;
        end
        pa[0] <= bus.req_addr;
        pe[0] <= dec_err;
        pd[0] <= dec_err ? 32'h0 : mem[dec_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wr_ptr[PW-1:0]] <= pa[LATENCY-1];
            fe[wr_ptr[PW-1:0]] <= pe[LATENCY-1];
            fd[wr_ptr[PW-1:0]] <= pd[LATENCY-1];
        end
    end

    // Buffer storage is not reset; outputs are masked to zero while empty.
    assign bus.rsp_valid = (wr_ptr != rd_ptr);
    assign bus.rsp_data  = bus.rsp_valid ? fd[rd_ptr[PW-1:0]] : 32'h0;
    assign bus.rsp_err   = bus.rsp_valid ? fe[rd_ptr[PW-1:0]] : 1'b0;
    assign bus.rsp_addr  = bus.rsp_valid ? fa[rd_ptr[PW-1:0]] : 32'h0;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - scoreboard bench for imem_fetch_responder
module tb_imem_fetch_responder;
    localparam logic [31:0] BASE    = 32'h0000_3000;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam int          QDEPTH  = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [9:0]  prog_idx;
    logic [31:0] prog_data;

    imem_fetch_responder_if bus ();

    imem_fetch_responder #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data)
    );

    logic [31:0] ref_mem [DEPTH];
    exp_t        q [$];
    int          cyc = 0;
    int          outstanding_m = 0;
    int          last_pop = -100;
    bit          head_shown = 0;
    int          e_cyc;
    int          checks = 0;
    int          passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [31:0] a, input int acc);
        exp_t   r;
        longint ua;
        ua     = longint'(a);
        r.addr = a;
        r.acc  = acc;
        r.err  = (a[1:0] != 2'b00) || (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4 * DEPTH);
        r.data = r.err ? 32'h0 : ref_mem[int'((ua - longint'(BASE)) / 4)];
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor and request logger; an accept seen here lands at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rst_req_ready", 32'(bus.req_ready), 0);
            check("rst_rsp_data", bus.rsp_data, 0);
            check("rst_rsp_err", 32'(bus.rsp_err), 0);
            check("rst_rsp_addr", bus.rsp_addr, 0);
            q.delete();
            outstanding_m = 0;
            head_shown    = 0;
            last_pop      = -100;
        end else begin
            check("req_ready", 32'(bus.req_ready), 32'(outstanding_m < QDEPTH));
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    check("spurious_rsp_valid", 1, 0);
                end else begin
                    if (!head_shown) begin
                        e_cyc = max2(q[0].acc + LATENCY, last_pop + 1);
                        check("rsp_latency", cyc, e_cyc);
                        head_shown = 1;
                    end
                    check("rsp_data", bus.rsp_data, q[0].data);
                    check("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
                    check("rsp_addr", bus.rsp_addr, q[0].addr);
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        last_pop   = cyc;
                        head_shown = 0;
                        outstanding_m--;
                    end
                end
            end else if (q.size() > 0 && !head_shown) begin
                e_cyc = max2(q[0].acc + LATENCY, last_pop + 1);
                if (cyc >= e_cyc) begin
                    check("rsp_valid_missing", 32'(bus.rsp_valid), 1);
                    head_shown = 1;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                q.push_back(model(bus.req_addr, cyc + 1));
                outstanding_m++;
            end
        end
        if (prog_we) ref_mem[prog_idx] = prog_data;
    end

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic prog(input int idx, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_idx  = 10'(idx);
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0, 1, 2, 3: return BASE + 32'(4 * ($urandom % 16));
            4:          return BASE + 32'($urandom % 64) | 32'h1;
            5:          return BASE - 32'(4 * (1 + $urandom % 4));
            6:          return BASE + 32'(4 * DEPTH - 4 + 4 * ($urandom % 3));
            default:    return ($urandom % 2) ? 32'hFFFF_FFFC : 32'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        prog_we       = 1'b0;
        prog_idx      = '0;
        prog_data     = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        prog(0, 32'h2008_0005);
        prog(1, 32'h2009_0003);
        prog(5, 32'h1111_1111);
        for (int i = 2; i < 16; i++) if (i != 5) prog(i, $urandom);
        prog(1023, $urandom);

        bus.rsp_ready = 1'b1;
        fetch(32'h3000);
        drain();

        fetch(32'h3000); fetch(32'h3004); fetch(32'h3008); fetch(32'h300C);
        drain();

        bus.rsp_ready = 1'b0;
        fetch(32'h3000); fetch(32'h3004); fetch(32'h3008); fetch(32'h300C);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h3010;
        repeat (3) begin @(posedge clk); #1; end
        bus.rsp_ready = 1'b1;
        fetch(32'h3010);
        drain();

        fetch(32'h3002); fetch(32'h2FFC); fetch(32'h3000 + 4 * 1024); fetch(32'h3FFC);
        drain();

        prog_we   = 1'b1;
        prog_idx  = 10'd5;
        prog_data = 32'hDEAD_BEEF;
        fetch(32'h3014);
        prog_we = 1'b0;
        fetch(32'h3014);
        drain();

        bus.rsp_ready = 1'b0;
        fetch(32'h3000); fetch(32'h3004); fetch(32'h3008);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_rsp_valid", 32'(bus.rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        fetch(32'h3004); fetch(32'h3008); fetch(32'h300C); fetch(32'h3010);
        bus.rsp_ready = 1'b1;
        drain();

        repeat (400) begin
            bus.req_valid = 1'($urandom % 2);
            bus.req_addr  = rand_addr();
            bus.rsp_ready = ($urandom % 4) != 0;
            prog_we       = ($urandom % 8) == 0;
            prog_idx      = 10'($urandom % 16);
            prog_data     = $urandom;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        prog_we       = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
